// File: rtl/hex_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
package hex_scan_ctrl_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

    // Counter width for a range of values 0..range-1, never narrower than one bit.
    function automatic int cnt_w(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/hex_scan_buf.sv
// Shadow/active double buffer for the display word with a valid/ready load port.
module hex_scan_buf
    import hex_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [4*N_DIGITS-1:0] data_i,
    input  logic [N_DIGITS-1:0]   en_i,
    input  logic                  xfer_i,
    output logic                  ready_o,
    output logic [4*N_DIGITS-1:0] act_data_o,
    output logic [N_DIGITS-1:0]   act_en_o
);

    logic [4*N_DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [N_DIGITS-1:0]   shadow_en_q, shadow_en_d;
    logic [4*N_DIGITS-1:0] act_data_q, act_data_d;
    logic [N_DIGITS-1:0]   act_en_q, act_en_d;
    logic                  pending_q, pending_d;
    logic                  accept;

    assign ready_o    = !pending_q;
    assign accept     = valid_i && !pending_q;
    assign act_data_o = act_data_q;
    assign act_en_o   = act_en_q;

    // A load can only coincide with a transfer when nothing is pending, so the
    // two branches never fight over the shadow contents.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_en_d   = shadow_en_q;
        act_data_d    = act_data_q;
        act_en_d      = act_en_q;
        pending_d     = pending_q;
        if (xfer_i && pending_q) begin
            act_data_d = shadow_data_q;
            act_en_d   = shadow_en_q;
            pending_d  = 1'b0;
        end
        if (accept) begin
            shadow_data_d = data_i;
            shadow_en_d   = en_i;
            pending_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_data_q <= '0;
            shadow_en_q   <= '0;
            act_data_q    <= '0;
            act_en_q      <= '0;
            pending_q     <= 1'b0;
        end else begin
            shadow_data_q <= shadow_data_d;
            shadow_en_q   <= shadow_en_d;
            act_data_q    <= act_data_d;
            act_en_q      <= act_en_d;
            pending_q     <= pending_d;
        end
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Scans N_DIGITS common-segment digits through one shared hex decoder, with
// dead time between digits and frame-aligned updates of the displayed word.
module hex_scan_ctrl
    import hex_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_valid,
    input  logic [4*N_DIGITS-1:0] load_data,
    input  logic [N_DIGITS-1:0]   load_enable,
    output logic                  load_ready,
    output logic [3:0]            dec_entrada,
    output logic                  dec_modo,
    input  logic [0:6]            dec_saida,
    output logic [0:6]            seg,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done
);

    localparam int CNT_RANGE = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int IDX_W     = cnt_w(N_DIGITS);
    localparam int CNT_W     = cnt_w(CNT_RANGE);

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [0:6]            seg_q;
    logic                  frame_done_q, frame_done_d;
    logic                  xfer;
    logic [N_DIGITS-1:0]   an_n;
    logic [4*N_DIGITS-1:0] act_data;
    logic [N_DIGITS-1:0]   act_en;

    hex_scan_buf #(
        .N_DIGITS (N_DIGITS)
    ) u_buf (
        .clk_i      (clock),
        .rst_i      (reset),
        .valid_i    (load_valid),
        .data_i     (load_data),
        .en_i       (load_enable),
        .xfer_i     (xfer),
        .ready_o    (load_ready),
        .act_data_o (act_data),
        .act_en_o   (act_en)
    );

    always_comb begin
        dec_entrada = '0;
        dec_modo    = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                dec_entrada = act_data[4*i +: 4];
                dec_modo    = act_en[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        frame_done_d = 1'b0;
        xfer         = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_n[i] = !((state_q == SHOW) && (idx_q == IDX_W'(i)));
        end
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d   = '0;
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHOW: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d   = '0;
                    state_d = BLANK;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        xfer         = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = BLANK;
        endcase
    end

    // idx already points at the upcoming digit during BLANK, so the registered
    // segments are settled by the first SHOW cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= BLANK;
            idx_q        <= '0;
            cnt_q        <= '0;
            seg_q        <= SEG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            seg_q        <= dec_saida;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_n;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
Time-multiplexed display scheduler that shares a single decode_HEX instance among N_DIGITS seven-segment digits. It holds a double-buffered digit word: a shadow register written through a valid/ready handshake, and an active register that drives the scan. The shadow is copied to the active register only at a frame boundary, so a frame never shows a mix of old and new digits. The block sits between the datapath result registers and the board's common-segment display pins.

Parameters:
N_DIGITS, 4, number of multiplexed digits (>=2).
SCAN_DIV, 50000, clock cycles each digit is lit per frame (>=1).
BLANK_CYC, 2, dead-time cycles with all digits off before each digit (>=1), for anti-ghosting.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
load_valid  in  1  new display word offered.
load_data  in  4*N_DIGITS  nibble i drives digit i; bits [3:0] = digit 0.
load_enable  in  N_DIGITS  per-digit enable; 1 = hex value, 0 = dash.
load_ready  out  1  shadow register free.
dec_entrada  out  4  nibble for the shared decoder.
dec_modo  out  1  enable for the shared decoder.
dec_saida  in  7  active-low segment pattern returned by the decoder, bits [0:6] = a..g.
seg  out  7  registered segment pins, active-low.
an  out  N_DIGITS  digit selects, active-low, one-hot-zero.
frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (asynchronous, immediate, also mid-frame) sets the following:
  - state=BLANK, idx=0, cnt=0.
  - an=all 1, seg=7'b1111111, frame_done=0.
  - active data=0, active enable=0, so "----" is shown until the first load takes effect.
  - shadow=0, pending=0, load_ready=1.
- dec_entrada = active nibble[idx]; dec_modo = active enable[idx]. Both are combinational from registers.
- seg <= dec_saida on every clock in both states.
- FSM has two states:
  - BLANK: an=all 1. cnt counts 0..BLANK_CYC-1, then cnt:=0 and the FSM goes to SHOW. Because BLANK_CYC>=1, seg is settled before the first SHOW cycle.
  - SHOW: an[idx]=0 and all other an bits are 1. cnt counts 0..SCAN_DIV-1. On the last count:
    - If idx<N_DIGITS-1: idx:=idx+1.
    - Else: idx:=0, frame_done pulses in the next cycle, and the frame-boundary transfer runs.
    - In both cases the FSM returns to BLANK.
- Frame length is N_DIGITS*(BLANK_CYC+SCAN_DIV) cycles.
- Handshake:
  - A load is accepted on a clock with load_valid & load_ready. It captures data and enable into the shadow and sets pending=1. load_ready = !pending.
  - load_valid may be held high; loads are never dropped and never double-accepted.
- Frame-boundary transfer:
  - If pending=1 on the last SHOW cycle of digit N_DIGITS-1: active:=shadow and pending:=0. The new word is displayed from digit 0 of the next frame, and load_ready rises the following cycle.
  - A load accepted on that same cycle (only possible when pending=0) goes to the shadow and is displayed after the following frame boundary, not this one.
- Digits are scanned in order 0..N_DIGITS-1. Exactly one an bit is low during SHOW and none during BLANK.
- idx and cnt widths are clog2 of their ranges; wrap is explicit, with no reliance on overflow.

Decomposition:
- Shared package holds the constant SEG_OFF=7'b1111111, the FSM state enum {BLANK, SHOW}, and a helper function returning the clog2-sized widths.
- One natural sub-module: hex_scan_buf, the shadow/active double buffer with the handshake and transfer input.
- The shared decode_HEX stays outside the block and is instantiated alongside it at the top level.

Test Plan:
All scenarios use N_DIGITS=4, SCAN_DIV=4, BLANK_CYC=2 (24-cycle frame).
1. Release reset, no load -> an sequence per frame: 1111×2, 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4. seg=1111110 whenever an≠1111. frame_done pulses once every 24 cycles.
2. Mid-frame load of data=16'h1234, enable=4'hF -> load_ready=0 next cycle; dashes remain until frame_done. In the next frame, SHOW seg = 1001100 (4), 0000110 (3), 0010010 (2), 1001111 (1) for digits 0..3. load_ready returns to 1 one cycle after the transfer.
3. Load data=16'hABCD, enable=4'b0101 -> digit0=1000010 (D), digit1=1111110, digit2=1100000 (B), digit3=1111110.
4. Load accepted on the last SHOW cycle of digit 3 with pending=0 -> the following frame still shows the old word, the frame after shows the new word, and frame_done pulses align.
5. Hold load_valid high with a second word while pending=1 -> no acceptance until the cycle after the transfer. The second word is accepted then, and is displayed one frame after the first word.
6. Assert reset during SHOW of digit 2 -> in the same cycle an=1111, seg=1111111, load_ready=1. After release, the first SHOW is digit 0 with dash, and the old pending word is discarded.
